// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

  // Width of a bit counter that must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Bit position a newly received bit enters the shift register at.
  function automatic int unsigned entry_bit(input int unsigned width, input bit lsb_first);
    return lsb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter: realigns on sync, counts valid bits and wraps after WIDTH, flagging the completing edge.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          sync_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    done_o = inc_i && !sync_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (sync_i) begin
      cnt_d = inc_i ? CW'(1) : '0;
    end else if (done_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sipo_frame_receiver.sv
// Deserializes a serial bit stream into WIDTH-bit words held behind a valid/ready handshake,
// flagging words lost to back-pressure in a sticky overrun bit.
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin,
  input  logic                        bit_valid,
  input  logic                        sync,
  output logic [WIDTH-1:0]            data_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        overrun,
  input  logic                        clr_ovr
);

  localparam int unsigned BIT_CNT_W = cnt_width(WIDTH);
  localparam int unsigned ENTRY     = entry_bit(WIDTH, LSB_FIRST != 0);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovr_q;

  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] seed_d;
  logic             done;
  logic             load_ok;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (BIT_CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (bit_valid),
    .sync_i (sync),
    .cnt_o  (bit_cnt),
    .done_o (done)
  );

  // A word always starts from an empty register, whatever the shift register holds in IDLE.
  always_comb begin
    shift_base    = (state_q == RECV) ? shift_q : '0;
    word_d        = (LSB_FIRST != 0) ? (shift_base >> 1) : (shift_base << 1);
    word_d[ENTRY] = sin;
    seed_d        = '0;
    seed_d[ENTRY] = sin;
  end

  // The holding register may take a new word if it is empty or being drained on this edge.
  assign load_ok = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (sync) begin
        shift_q <= bit_valid ? seed_d : '0;
        state_q <= bit_valid ? RECV : IDLE;
      end else if (bit_valid) begin
        shift_q <= done ? '0 : word_d;
        state_q <= done ? IDLE : RECV;
      end

      if (done && load_ok) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      // A drop on the same edge as a clear leaves overrun set.
      if (done && !load_ok) begin
        ovr_q <= 1'b1;
      end else if (clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Self-checking bench: directed vector table, PISO loopback, random run against a word-level
// model (WIDTH=4, LSB first) and an async-reset sequence on an MSB-first WIDTH=8 instance.
module tb_sipo_frame_receiver;

  localparam int WA = 4;
  localparam int WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, a_sin, a_bv, a_sync, a_rdy, a_clr;
  logic [WA-1:0] a_data;
  logic          a_valid, a_ovr;
  logic [2:0]    a_cnt;

  logic          rst_b, b_sin, b_bv, b_sync, b_rdy, b_clr;
  logic [WB-1:0] b_data;
  logic          b_valid, b_ovr;
  logic [3:0]    b_cnt;

  sipo_frame_receiver #(.WIDTH(WA), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst_a), .sin(a_sin), .bit_valid(a_bv), .sync(a_sync),
    .data_out(a_data), .out_valid(a_valid), .out_ready(a_rdy),
    .bit_cnt(a_cnt), .overrun(a_ovr), .clr_ovr(a_clr)
  );

  sipo_frame_receiver #(.WIDTH(WB), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst_b), .sin(b_sin), .bit_valid(b_bv), .sync(b_sync),
    .data_out(b_data), .out_valid(b_valid), .out_ready(b_rdy),
    .bit_cnt(b_cnt), .overrun(b_ovr), .clr_ovr(b_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       sin, bv, sync, rdy, clr;
    logic [3:0] data;
    logic       valid;
    logic [2:0] cnt;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int s, input int bv, input int sy, input int rd, input int cl,
                              input int d, input int v, input int c, input int o);
    vec_t r;
    r.sin = s[0]; r.bv = bv[0]; r.sync = sy[0]; r.rdy = rd[0]; r.clr = cl[0];
    r.data = d[3:0]; r.valid = v[0]; r.cnt = c[2:0]; r.ovr = o[0];
    return r;
  endfunction

  task automatic drive_a(input logic s, input logic bv, input logic sy, input logic rd, input logic cl);
    a_sin = s; a_bv = bv; a_sync = sy; a_rdy = rd; a_clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic s, input logic bv, input logic rd);
    b_sin = s; b_bv = bv; b_sync = 1'b0; b_rdy = rd; b_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: collect bits in a queue, assemble on the WIDTH-th bit.
  bit         m_bits[$];
  logic [3:0] m_data;
  logic       m_valid, m_ovr;

  function automatic void model_reset();
    m_bits.delete();
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endfunction

  function automatic void model_edge(input logic s, input logic bv, input logic sy, input logic rd, input logic cl);
    bit         complete = 1'b0;
    bit         dropped  = 1'b0;
    logic [3:0] w        = '0;
    if (sy) begin
      m_bits.delete();
      if (bv) m_bits.push_back(s);
    end else if (bv) begin
      m_bits.push_back(s);
      if (m_bits.size() == WA) begin
        complete = 1'b1;
        for (int i = 0; i < WA; i++) w[i] = m_bits[i];
        m_bits.delete();
      end
    end
    if (complete) begin
      if (!m_valid || rd) begin
        m_data = w; m_valid = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (cl) m_ovr = 1'b0;
  endfunction

  initial begin
    logic [3:0] loop_words [2];
    logic [3:0] piso_q;
    logic [7:0] wb;
    logic       s, bv, sy, rd, cl;

    {a_sin, a_bv, a_sync, a_rdy, a_clr} = '0;
    {b_sin, b_bv, b_sync, b_rdy, b_clr} = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    #12;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("rst_a_data", a_data, 0);  check("rst_a_valid", a_valid, 0);
    check("rst_a_cnt", a_cnt, 0);    check("rst_a_ovr", a_ovr, 0);
    check("rst_b_data", b_data, 0);  check("rst_b_valid", b_valid, 0);

    // nominal word 1,1,0,1 -> 1011, valid for exactly one cycle
    vecs.push_back(mk(1,1,0,1,0, 'h0,0,1,0));
    vecs.push_back(mk(1,1,0,1,0, 'h0,0,2,0));
    vecs.push_back(mk(0,1,0,1,0, 'h0,0,3,0));
    vecs.push_back(mk(1,1,0,1,0, 'hB,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 'hB,0,0,0));
    // back-pressure: 1011 held, 0011 dropped, overrun set then cleared, then consumed
    vecs.push_back(mk(1,1,0,0,0, 'hB,0,1,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,0,2,0));
    vecs.push_back(mk(0,1,0,0,0, 'hB,0,3,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,1,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,2,0));
    vecs.push_back(mk(0,1,0,0,0, 'hB,1,3,0));
    vecs.push_back(mk(0,1,0,0,0, 'hB,1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 'hB,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 'hB,0,0,0));
    // simultaneous accept: 1011 held, 0101 completes with out_ready=1
    vecs.push_back(mk(1,1,0,0,0, 'hB,0,1,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,0,2,0));
    vecs.push_back(mk(0,1,0,0,0, 'hB,0,3,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,1,0));
    vecs.push_back(mk(0,1,0,0,0, 'hB,1,2,0));
    vecs.push_back(mk(1,1,0,0,0, 'hB,1,3,0));
    vecs.push_back(mk(0,1,0,1,0, 'h5,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 'h5,0,0,0));
    // sync realign with a valid bit -> 1001; then sync without bit leaves output alone
    vecs.push_back(mk(1,1,0,1,0, 'h5,0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 'h5,0,2,0));
    vecs.push_back(mk(1,1,1,1,0, 'h5,0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 'h5,0,2,0));
    vecs.push_back(mk(0,0,0,1,0, 'h5,0,2,0));
    vecs.push_back(mk(0,1,0,1,0, 'h5,0,3,0));
    vecs.push_back(mk(1,1,0,1,0, 'h9,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 'h9,1,1,0));
    vecs.push_back(mk(0,0,1,0,0, 'h9,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 'h9,0,0,0));
    // overrun set and clear on the same edge: set wins
    vecs.push_back(mk(1,1,0,0,0, 'h9,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 'h9,0,2,0));
    vecs.push_back(mk(0,1,0,0,0, 'h9,0,3,0));
    vecs.push_back(mk(0,1,0,0,0, 'h1,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 'h1,1,1,0));
    vecs.push_back(mk(1,1,0,0,0, 'h1,1,2,0));
    vecs.push_back(mk(1,1,0,0,0, 'h1,1,3,0));
    vecs.push_back(mk(1,1,0,0,1, 'h1,1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 'h1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 'h1,0,0,0));

    foreach (vecs[i]) begin
      drive_a(vecs[i].sin, vecs[i].bv, vecs[i].sync, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_data", i), a_data, vecs[i].data);
      check($sformatf("vec%0d_valid", i), a_valid, vecs[i].valid);
      check($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].cnt);
      check($sformatf("vec%0d_ovr", i), a_ovr, vecs[i].ovr);
    end

    // loopback from an LSB-first PISO shifter loaded with 1011 then 0110
    loop_words[0] = 4'b1011;
    loop_words[1] = 4'b0110;
    for (int w = 0; w < 2; w++) begin
      piso_q = loop_words[w];
      for (int b = 0; b < WA; b++) begin
        drive_a(piso_q[0], 1'b1, 1'b0, 1'b1, 1'b0);
        piso_q = piso_q >> 1;
      end
      check("loop_data", a_data, loop_words[w]);
      check("loop_valid", a_valid, 1);
      check("loop_ovr", a_ovr, 0);
    end

    // randomized run against the model, from a fresh reset
    a_bv = 1'b0; a_sync = 1'b0; a_clr = 1'b0;
    rst_a = 1'b0;
    #2;
    rst_a = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      s  = 1'($urandom_range(1, 0));
      bv = ($urandom_range(9, 0) < 7);
      sy = ($urandom_range(19, 0) == 0);
      rd = ($urandom_range(1, 0) == 1);
      cl = ($urandom_range(9, 0) == 0);
      drive_a(s, bv, sy, rd, cl);
      model_edge(s, bv, sy, rd, cl);
      check("rnd_data", a_data, m_data);
      check("rnd_valid", a_valid, m_valid);
      check("rnd_cnt", a_cnt, m_bits.size());
      check("rnd_ovr", a_ovr, m_ovr);
    end

    // WIDTH=8 MSB first: fill output, force overrun, start a word, then async reset
    wb = 8'hCA;
    for (int i = WB - 1; i >= 0; i--) drive_b(wb[i], 1'b1, 1'b0);
    check("b_word_ca", b_data, 8'hCA);
    check("b_valid_ca", b_valid, 1);
    for (int i = 0; i < WB; i++) drive_b(1'b1, 1'b1, 1'b0);
    check("b_ovr_set", b_ovr, 1);
    check("b_data_kept", b_data, 8'hCA);
    for (int i = 0; i < 3; i++) drive_b(1'b1, 1'b1, 1'b0);
    check("b_cnt_mid", b_cnt, 3);
    b_bv = 1'b0;
    rst_b = 1'b0;
    #2;
    check("b_rst_data", b_data, 0);
    check("b_rst_valid", b_valid, 0);
    check("b_rst_cnt", b_cnt, 0);
    check("b_rst_ovr", b_ovr, 0);
    #1;
    rst_b = 1'b1;
    wb = 8'b10100111;
    for (int i = WB - 1; i >= 0; i--) begin
      drive_b(wb[i], 1'b1, 1'b1);
      if (i == WB - 1) check("b_first_cnt", b_cnt, 1);
    end
    check("b_word", b_data, 8'b10100111);
    check("b_valid", b_valid, 1);
    check("b_cnt_end", b_cnt, 0);
    check("b_ovr_end", b_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
